srl_tap_reader: RTL and testbench

Read-side sequencer for the 128×8 addressable shift-register delay line. It gates upstream samples into the delay line and, on command, walks a window of taps. Each tap is presented on a valid/ready output stream, with the window's final sample flagged. It sits between the sample source, the delay line (driving its d/ce/a, observing its y) and downstream tap consumers (FIR/correlator MAC).

---
 rtl/srl_tap_reader.sv | 146 ++++++++++++++
 tb/tb_srl_tap_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/srl_tap_reader.sv
// -----------------------------------------------------------------------------
// srl_tap_reader
//
// Read-side sequencer for a 2^AW x W addressable shift-register delay line.
// While idle it passes upstream samples into the delay line. On a start
// command it freezes the line and walks taps base, base+1, ... base+len
// (modulo 2^AW, toward older samples). Each tap is offered on a valid/ready
// stream, and the final tap of the window is flagged with o_dout_last.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   i_din        upstream sample
//   i_din_stb    upstream sample present (held until accepted)
//   o_din_rdy    sample accepted when i_din_stb & o_din_rdy
//   o_sr_d       delay line d (combinational copy of i_din)
//   o_sr_ce      delay line ce (i_din_stb & o_din_rdy)
//   o_sr_a       delay line tap address (registered)
//   i_sr_y       delay line tap output (combinational in o_sr_a)
//   i_start      burst request, sampled only in IDLE
//   i_base       first tap address (0 = newest sample)
//   i_len        tap count minus one
//   o_dout       tap sample
//   o_dout_vld   o_dout valid
//   i_dout_rdy   downstream accepts
//   o_dout_last  o_dout is the final tap of the burst
//   o_busy       burst in progress
// -----------------------------------------------------------------------------
module srl_tap_reader #(
    parameter int AW = 7,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  i_din,
    input  logic          i_din_stb,
    output logic          o_din_rdy,
    output logic [W-1:0]  o_sr_d,
    output logic          o_sr_ce,
    output logic [AW-1:0] o_sr_a,
    input  logic [W-1:0]  i_sr_y,
    input  logic          i_start,
    input  logic [AW-1:0] i_base,
    input  logic [AW-1:0] i_len,
    output logic [W-1:0]  o_dout,
    output logic          o_dout_vld,
    input  logic          i_dout_rdy,
    output logic          o_dout_last,
    output logic          o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_sr_a;
    logic [AW-1:0] r_cnt;
    logic [W-1:0]  r_dout;
    logic          r_dout_vld;
    logic          r_dout_last;

    state_t        w_state;
    logic [AW-1:0] w_sr_a;
    logic [AW-1:0] w_cnt;
    logic [W-1:0]  w_dout;
    logic          w_dout_vld;
    logic          w_dout_last;

    // NOTE: every signal written here takes its current value first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        w_state     = r_state;
        w_sr_a      = r_sr_a;
        w_cnt       = r_cnt;
        w_dout      = r_dout;
        w_dout_vld  = r_dout_vld;
        w_dout_last = r_dout_last;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_sr_a  = i_base;
                    w_cnt   = i_len;
                    w_state = S_FETCH;
                end
            end
            // The address was set on entry here, so i_sr_y has had a full
            // cycle to settle before it is captured.
            S_FETCH: begin
                w_dout      = i_sr_y;
                w_dout_vld  = 1'b1;
                w_dout_last = (r_cnt == '0);
                w_state     = S_HOLD;
            end
            S_HOLD: begin
                if (i_dout_rdy) begin
                    w_dout_vld = 1'b0;
                    if (r_dout_last) begin
                        w_dout_last = 1'b0;
                        w_state     = S_IDLE;
                    end else begin
                        // Natural AW-bit wrap gives the modulo-2^AW walk.
                        w_sr_a  = r_sr_a + AW'(1);
                        w_cnt   = r_cnt - AW'(1);
                        w_state = S_FETCH;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sr_a      <= '0;
            r_cnt       <= '0;
            r_dout      <= '0;
            r_dout_vld  <= 1'b0;
            r_dout_last <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_sr_a      <= w_sr_a;
            r_cnt       <= w_cnt;
            r_dout      <= w_dout;
            r_dout_vld  <= w_dout_vld;
            r_dout_last <= w_dout_last;
        end
    end

    // The delay line is frozen for the whole burst; upstream simply waits.
    assign o_din_rdy   = (r_state == S_IDLE);
    assign o_sr_ce     = i_din_stb & o_din_rdy;
    assign o_sr_d      = i_din;
    assign o_sr_a      = r_sr_a;
    assign o_dout      = r_dout;
    assign o_dout_vld  = r_dout_vld;
    assign o_dout_last = r_dout_last;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_srl_tap_reader.sv
// -----------------------------------------------------------------------------
// tb_srl_tap_reader
//
// Self-checking bench for srl_tap_reader. A behavioural 128x8 delay line is
// attached to the sr_* ports. Expected taps come from a sample-history queue
// (newest first) updated whenever the bench itself hands a sample upstream.
// -----------------------------------------------------------------------------
module tb_srl_tap_reader;

    localparam int AW    = 7;
    localparam int W     = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  i_din;
    logic          i_din_stb;
    logic          o_din_rdy;
    logic [W-1:0]  o_sr_d;
    logic          o_sr_ce;
    logic [AW-1:0] o_sr_a;
    logic [W-1:0]  i_sr_y;
    logic          i_start;
    logic [AW-1:0] i_base;
    logic [AW-1:0] i_len;
    logic [W-1:0]  o_dout;
    logic          o_dout_vld;
    logic          i_dout_rdy;
    logic          o_dout_last;
    logic          o_busy;

    int tests = 0;
    int fails = 0;

    // Reference history: hist[k] is the sample accepted k shifts ago.
    byte unsigned hist[$];

    always #5 clk = ~clk;

    srl_tap_reader #(.AW(AW), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_din      (i_din),
        .i_din_stb  (i_din_stb),
        .o_din_rdy  (o_din_rdy),
        .o_sr_d     (o_sr_d),
        .o_sr_ce    (o_sr_ce),
        .o_sr_a     (o_sr_a),
        .i_sr_y     (i_sr_y),
        .i_start    (i_start),
        .i_base     (i_base),
        .i_len      (i_len),
        .o_dout     (o_dout),
        .o_dout_vld (o_dout_vld),
        .i_dout_rdy (i_dout_rdy),
        .o_dout_last(o_dout_last),
        .o_busy     (o_busy)
    );

    // Behavioural delay line driven by the DUT.
    logic [W-1:0] dl_mem [DEPTH] = '{default: '0};

    always @(posedge clk) begin
        if (o_sr_ce) begin
            for (int k = DEPTH - 1; k > 0; k--) dl_mem[k] <= dl_mem[k-1];
            dl_mem[0] <= o_sr_d;
        end
    end

    assign i_sr_y = dl_mem[o_sr_a];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input byte unsigned v);
        hist.push_front(v);
        void'(hist.pop_back());
    endtask

    function automatic logic [31:0] tap(input int addr);
        return 32'(hist[addr % DEPTH]);
    endfunction

    task automatic shift_in(input byte unsigned v);
        i_din     = v;
        i_din_stb = 1'b1;
        #1;
        chk("shift_ce", 32'(o_sr_ce), 1);
        chk("shift_d", 32'(o_sr_d), 32'(v));
        tick();
        model_push(v);
        i_din_stb = 1'b0;
    endtask

    // Randomise the inputs the DUT must ignore while a burst runs.
    task automatic noise();
        i_start = 1'($urandom);
        i_base  = AW'($urandom);
        i_len   = AW'($urandom);
    endtask

    // One complete burst from the IDLE cycle of the start request to the
    // first IDLE cycle afterwards. stall_n cycles of dout_rdy=0 are inserted
    // on tap stall_tap. stb_start presents a sample together with start;
    // stb_during holds 0x55 on the upstream port for the whole burst.
    task automatic run_burst(input int b, input int l, input int stall_tap, input int stall_n,
                             input bit stb_start, input bit stb_during);
        int cyc = 0;
        int stalls = 0;
        int addr;
        byte unsigned v = byte'($urandom);
        i_start    = 1'b1;
        i_base     = AW'(b);
        i_len      = AW'(l);
        i_din      = v;
        i_din_stb  = stb_start;
        i_dout_rdy = 1'b1;
        #1;
        chk("start_busy", 32'(o_busy), 0);
        chk("start_din_rdy", 32'(o_din_rdy), 1);
        chk("start_ce", 32'(o_sr_ce), 32'(stb_start));
        tick();
        cyc++;
        if (stb_start) model_push(v);
        i_din_stb = stb_during;
        i_din     = 8'h55;
        for (int i = 0; i <= l; i++) begin
            addr = (b + i) % DEPTH;
            noise();
            i_dout_rdy = 1'($urandom);
            #1;
            chk("fetch_a", 32'(o_sr_a), 32'(addr));
            chk("fetch_vld", 32'(o_dout_vld), 0);
            chk("fetch_busy", 32'(o_busy), 1);
            chk("fetch_din_rdy", 32'(o_din_rdy), 0);
            chk("fetch_ce", 32'(o_sr_ce), 0);
            tick();
            cyc++;
            for (int s = 0; s <= ((i == stall_tap) ? stall_n : 0); s++) begin
                noise();
                i_dout_rdy = (s == ((i == stall_tap) ? stall_n : 0));
                if (i == l && i_dout_rdy) i_start = 1'b0;
                #1;
                chk("hold_vld", 32'(o_dout_vld), 1);
                chk("hold_dout", 32'(o_dout), tap(addr));
                chk("hold_last", 32'(o_dout_last), 32'(i == l));
                chk("hold_a", 32'(o_sr_a), 32'(addr));
                chk("hold_ce", 32'(o_sr_ce), 0);
                tick();
                cyc++;
                if (!i_dout_rdy) stalls++;
            end
        end
        #1;
        chk("end_busy", 32'(o_busy), 0);
        chk("end_din_rdy", 32'(o_din_rdy), 1);
        chk("end_vld", 32'(o_dout_vld), 0);
        chk("end_last", 32'(o_dout_last), 0);
        chk("burst_cycles", 32'(cyc), 32'(3 + 2 * l + stalls));
        if (stb_during) begin
            chk("release_ce", 32'(o_sr_ce), 1);
            tick();
            model_push(8'h55);
            i_din_stb = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) hist.push_back(8'h00);
        rst        = 1'b1;
        i_din      = '0;
        i_din_stb  = 1'b0;
        i_start    = 1'b0;
        i_base     = '0;
        i_len      = '0;
        i_dout_rdy = 1'b1;

        // Power-on reset.
        #2;
        chk("rst_vld", 32'(o_dout_vld), 0);
        chk("rst_last", 32'(o_dout_last), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_a", 32'(o_sr_a), 0);
        chk("rst_dout", 32'(o_dout), 0);
        chk("rst_din_rdy", 32'(o_din_rdy), 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Basic burst: 0x0A, 0x09, 0x08, 0x07.
        for (int i = 1; i <= 10; i++) shift_in(byte'(i));
        chk("basic_tap0_ref", tap(0), 32'h0A);
        chk("basic_tap3_ref", tap(3), 32'h07);
        run_burst(0, 3, -1, 0, 1'b0, 1'b0);

        // Address wrap: 126, 127, 0, 1 -> 0x03, 0x02, 0x81, 0x80.
        for (int i = 0; i < 130; i++) shift_in(byte'(i));
        chk("wrap_tap126_ref", tap(126), 32'h03);
        chk("wrap_tap1_ref", tap(1), 32'h80);
        run_burst(126, 3, -1, 0, 1'b0, 1'b0);

        // Backpressure: five stall cycles on the second tap.
        run_burst(5, 3, 1, 5, 1'b0, 1'b0);

        // Back-to-back burst with a sample arriving together with start.
        run_burst(0, 2, -1, 0, 1'b1, 1'b0);

        // Upstream stall, then read the single 0x55 back.
        run_burst(10, 3, 2, 2, 1'b0, 1'b1);
        run_burst(0, 0, -1, 0, 1'b0, 1'b0);

        // Randomised bursts.
        for (int r = 0; r < 8; r++) begin
            int l;
            repeat ($urandom_range(0, 5)) shift_in(byte'($urandom));
            l = $urandom_range(0, 15);
            run_burst($urandom_range(0, DEPTH - 1), l, $urandom_range(0, l),
                      $urandom_range(0, 4), 1'($urandom), 1'b0);
        end

        // Reset abort after two taps of a len=10 burst.
        i_start    = 1'b1;
        i_base     = '0;
        i_len      = AW'(10);
        i_dout_rdy = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (4) tick();
        #3;
        rst = 1'b1;
        #1;
        chk("abort_vld", 32'(o_dout_vld), 0);
        chk("abort_last", 32'(o_dout_last), 0);
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_a", 32'(o_sr_a), 0);
        chk("abort_dout", 32'(o_dout), 0);
        chk("abort_din_rdy", 32'(o_din_rdy), 1);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("post_abort_vld", 32'(o_dout_vld), 0);
            chk("post_abort_busy", 32'(o_busy), 0);
            tick();
        end

        // Full 128-tap window over the untouched delay line.
        run_burst(0, DEPTH - 1, -1, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
